// File: rtl/sasanqua_exec_merge_pkg.sv
// Shared sasanqua definitions: merge FSM states, exception codes and the
// registered writeback record used by the exec merge stage.
package sasanqua_exec_merge_pkg;

  typedef enum logic {
    StRun  = 1'b0,
    StTrap = 1'b1
  } state_e;

  localparam logic [3:0] EXC_ILLEGAL = 4'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        reg_w_en;
    logic [4:0]  reg_w_rd;
    logic [31:0] reg_w_data;
    logic        exc_en;
    logic [3:0]  exc_code;
  } wb_t;

  // Single-source result; a write to x0 or a faulting instruction never writes.
  function automatic wb_t make_wb(input logic [31:0] pc, input logic w_en,
                                  input logic [4:0] rd, input logic [31:0] data,
                                  input logic exc_en, input logic [3:0] exc_code);
    wb_t wb;
    wb.valid      = 1'b1;
    wb.pc         = pc;
    wb.reg_w_en   = w_en && (rd != 5'd0) && !exc_en;
    wb.reg_w_rd   = rd;
    wb.reg_w_data = data;
    wb.exc_en     = exc_en;
    wb.exc_code   = exc_code;
    return wb;
  endfunction

endpackage

// File: rtl/sasanqua_exec_merge_if.sv
// Exec-stage bus between the core/coprocessor and the writeback merge stage.
interface sasanqua_exec_merge_if #(
  parameter int unsigned CNT_W = 32
);
  logic             FLUSH;
  logic             STALL;
  logic             MEM_WAIT;

  logic             MAIN_VALID;
  logic [31:0]      MAIN_PC;
  logic             MAIN_REG_W_EN;
  logic [4:0]       MAIN_REG_W_RD;
  logic [31:0]      MAIN_REG_W_DATA;
  logic             MAIN_EXC_EN;
  logic [3:0]       MAIN_EXC_CODE;

  logic             COP_E_ALLOW;
  logic             COP_E_VALID;
  logic [31:0]      COP_E_PC;
  logic             COP_E_REG_W_EN;
  logic [4:0]       COP_E_REG_W_RD;
  logic [31:0]      COP_E_REG_W_DATA;
  logic             COP_E_EXC_EN;
  logic [3:0]       COP_E_EXC_CODE;

  logic             WB_VALID;
  logic [31:0]      WB_PC;
  logic             WB_REG_W_EN;
  logic [4:0]       WB_REG_W_RD;
  logic [31:0]      WB_REG_W_DATA;
  logic             WB_EXC_EN;
  logic [3:0]       WB_EXC_CODE;
  logic [CNT_W-1:0] COP_RETIRE_CNT;
  logic             PROTO_ERR;

  modport master (
    output FLUSH, STALL, MEM_WAIT,
    output MAIN_VALID, MAIN_PC, MAIN_REG_W_EN, MAIN_REG_W_RD, MAIN_REG_W_DATA,
    output MAIN_EXC_EN, MAIN_EXC_CODE,
    output COP_E_ALLOW, COP_E_VALID, COP_E_PC, COP_E_REG_W_EN, COP_E_REG_W_RD,
    output COP_E_REG_W_DATA, COP_E_EXC_EN, COP_E_EXC_CODE,
    input  WB_VALID, WB_PC, WB_REG_W_EN, WB_REG_W_RD, WB_REG_W_DATA,
    input  WB_EXC_EN, WB_EXC_CODE, COP_RETIRE_CNT, PROTO_ERR
  );

  modport slave (
    input  FLUSH, STALL, MEM_WAIT,
    input  MAIN_VALID, MAIN_PC, MAIN_REG_W_EN, MAIN_REG_W_RD, MAIN_REG_W_DATA,
    input  MAIN_EXC_EN, MAIN_EXC_CODE,
    input  COP_E_ALLOW, COP_E_VALID, COP_E_PC, COP_E_REG_W_EN, COP_E_REG_W_RD,
    input  COP_E_REG_W_DATA, COP_E_EXC_EN, COP_E_EXC_CODE,
    output WB_VALID, WB_PC, WB_REG_W_EN, WB_REG_W_RD, WB_REG_W_DATA,
    output WB_EXC_EN, WB_EXC_CODE, COP_RETIRE_CNT, PROTO_ERR
  );

endinterface

// File: rtl/sasanqua_retire_cnt.sv
// Wrapping retire counter for coprocessor instructions.
module sasanqua_retire_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  output logic [CNT_W-1:0] CNT
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (EN) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/sasanqua_exec_merge.sv
// Merges core and coprocessor exec results into one registered writeback slot,
// trapping on exceptions and on a same-cycle double issue.
module sasanqua_exec_merge
  import sasanqua_exec_merge_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic                     CLK,
  input logic                     RST,
  sasanqua_exec_merge_if.slave    bus
);

  state_e           state_q, state_d;
  wb_t              wb_q, wb_d;
  logic             proto_err_q, proto_err_d;
  logic             cnt_en;
  logic             cop_valid;
  logic             capture;
  logic [CNT_W-1:0] retire_cnt;

  assign cop_valid = bus.COP_E_ALLOW && bus.COP_E_VALID;
  assign capture   = (state_q == StRun) && !bus.STALL && !bus.MEM_WAIT;

  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    wb_d.valid  = 1'b0;
    proto_err_d = proto_err_q;
    cnt_en      = 1'b0;

    if (bus.FLUSH) begin
      state_d     = StRun;
      wb_d.exc_en = 1'b0;
    end else if (capture) begin
      if (bus.MAIN_VALID && cop_valid) begin
        // Double issue: report as illegal instruction against the core PC.
        wb_d.valid    = 1'b1;
        wb_d.pc       = bus.MAIN_PC;
        wb_d.reg_w_en = 1'b0;
        wb_d.exc_en   = 1'b1;
        wb_d.exc_code = EXC_ILLEGAL;
        proto_err_d   = 1'b1;
      end else if (bus.MAIN_VALID) begin
        wb_d = make_wb(bus.MAIN_PC, bus.MAIN_REG_W_EN, bus.MAIN_REG_W_RD,
                       bus.MAIN_REG_W_DATA, bus.MAIN_EXC_EN, bus.MAIN_EXC_CODE);
      end else if (cop_valid) begin
        wb_d   = make_wb(bus.COP_E_PC, bus.COP_E_REG_W_EN, bus.COP_E_REG_W_RD,
                         bus.COP_E_REG_W_DATA, bus.COP_E_EXC_EN, bus.COP_E_EXC_CODE);
        cnt_en = !bus.COP_E_EXC_EN;
      end
      if (wb_d.valid && wb_d.exc_en) begin
        state_d = StTrap;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= StRun;
      wb_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      proto_err_q <= proto_err_d;
    end
  end

  sasanqua_retire_cnt #(
    .CNT_W (CNT_W)
  ) u_retire_cnt (
    .CLK (CLK),
    .RST (RST),
    .EN  (cnt_en),
    .CNT (retire_cnt)
  );

  assign bus.WB_VALID       = wb_q.valid;
  assign bus.WB_PC          = wb_q.pc;
  assign bus.WB_REG_W_EN    = wb_q.reg_w_en;
  assign bus.WB_REG_W_RD    = wb_q.reg_w_rd;
  assign bus.WB_REG_W_DATA  = wb_q.reg_w_data;
  assign bus.WB_EXC_EN      = wb_q.exc_en;
  assign bus.WB_EXC_CODE    = wb_q.exc_code;
  assign bus.COP_RETIRE_CNT = retire_cnt;
  assign bus.PROTO_ERR      = proto_err_q;

endmodule

// File: tb/tb_sasanqua_exec_merge.sv
// Bench for sasanqua_exec_merge: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_sasanqua_exec_merge;

  localparam int unsigned CW = 4;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  sasanqua_exec_merge_if #(.CNT_W(CW)) bus ();

  sasanqua_exec_merge #(
    .CNT_W (CW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: what the writeback slot must show after each edge.
  bit              m_trap;
  bit              m_v, m_en, m_exc, m_perr, m_known;
  logic [31:0]     m_pc, m_data;
  logic [4:0]      m_rd;
  logic [3:0]      m_code;
  int unsigned     m_cnt;

  initial begin
    m_trap = 0; m_v = 0; m_en = 0; m_exc = 0; m_perr = 0; m_known = 1;
    m_pc = '0; m_data = '0; m_rd = '0; m_code = '0; m_cnt = 0;
  end

  always @(posedge CLK) begin
    bit cop_ok;
    cop_ok = bus.COP_E_ALLOW && bus.COP_E_VALID;
    if (!RST) begin
      m_trap = 0; m_v = 0; m_en = 0; m_exc = 0; m_perr = 0; m_known = 1;
      m_pc = '0; m_data = '0; m_rd = '0; m_code = '0; m_cnt = 0;
    end else if (bus.FLUSH) begin
      m_trap = 0; m_v = 0; m_exc = 0;
    end else if (m_trap || bus.STALL || bus.MEM_WAIT) begin
      m_v = 0;
    end else if (bus.MAIN_VALID && cop_ok) begin
      m_v = 1; m_pc = bus.MAIN_PC; m_en = 0; m_exc = 1; m_code = 4'd2;
      m_perr = 1; m_known = 0; m_trap = 1;
    end else if (bus.MAIN_VALID) begin
      m_v = 1; m_pc = bus.MAIN_PC; m_rd = bus.MAIN_REG_W_RD;
      m_data = bus.MAIN_REG_W_DATA; m_exc = bus.MAIN_EXC_EN; m_code = bus.MAIN_EXC_CODE;
      m_en = bus.MAIN_REG_W_EN && (m_rd != 0) && !m_exc;
      m_known = 1;
      if (m_exc) m_trap = 1;
    end else if (cop_ok) begin
      m_v = 1; m_pc = bus.COP_E_PC; m_rd = bus.COP_E_REG_W_RD;
      m_data = bus.COP_E_REG_W_DATA; m_exc = bus.COP_E_EXC_EN; m_code = bus.COP_E_EXC_CODE;
      m_en = bus.COP_E_REG_W_EN && (m_rd != 0) && !m_exc;
      m_known = 1;
      if (m_exc) m_trap = 1;
      else m_cnt = (m_cnt + 1) % (1 << CW);
    end else begin
      m_v = 0;
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge CLK) begin
    bit bad;
    bad = (bus.WB_VALID !== m_v) || (bus.WB_PC !== m_pc) || (bus.WB_REG_W_EN !== m_en) ||
          (bus.WB_EXC_EN !== m_exc) || (bus.WB_EXC_CODE !== m_code) ||
          (bus.PROTO_ERR !== m_perr) || (bus.COP_RETIRE_CNT !== CW'(m_cnt)) ||
          (m_known && ((bus.WB_REG_W_RD !== m_rd) || (bus.WB_REG_W_DATA !== m_data)));
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL model t=%0t got v=%b pc=%h en=%b rd=%0d d=%h exc=%b code=%0d cnt=%0d perr=%b required v=%b pc=%h en=%b rd=%0d d=%h exc=%b code=%0d cnt=%0d perr=%b",
               $time, bus.WB_VALID, bus.WB_PC, bus.WB_REG_W_EN, bus.WB_REG_W_RD,
               bus.WB_REG_W_DATA, bus.WB_EXC_EN, bus.WB_EXC_CODE, bus.COP_RETIRE_CNT,
               bus.PROTO_ERR, m_v, m_pc, m_en, m_rd, m_data, m_exc, m_code, m_cnt, m_perr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle();
    RST = 1'b1;
    bus.FLUSH = 0; bus.STALL = 0; bus.MEM_WAIT = 0;
    bus.MAIN_VALID = 0; bus.MAIN_PC = '0; bus.MAIN_REG_W_EN = 0; bus.MAIN_REG_W_RD = '0;
    bus.MAIN_REG_W_DATA = '0; bus.MAIN_EXC_EN = 0; bus.MAIN_EXC_CODE = '0;
    bus.COP_E_ALLOW = 0; bus.COP_E_VALID = 0; bus.COP_E_PC = '0; bus.COP_E_REG_W_EN = 0;
    bus.COP_E_REG_W_RD = '0; bus.COP_E_REG_W_DATA = '0; bus.COP_E_EXC_EN = 0;
    bus.COP_E_EXC_CODE = '0;
  endtask

  task automatic set_main(input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] data, input logic exc, input logic [3:0] code);
    bus.MAIN_VALID = 1; bus.MAIN_PC = pc; bus.MAIN_REG_W_EN = 1; bus.MAIN_REG_W_RD = rd;
    bus.MAIN_REG_W_DATA = data; bus.MAIN_EXC_EN = exc; bus.MAIN_EXC_CODE = code;
  endtask

  task automatic set_cop(input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] data, input logic exc, input logic [3:0] code);
    bus.COP_E_ALLOW = 1; bus.COP_E_VALID = 1; bus.COP_E_PC = pc; bus.COP_E_REG_W_EN = 1;
    bus.COP_E_REG_W_RD = rd; bus.COP_E_REG_W_DATA = data; bus.COP_E_EXC_EN = exc;
    bus.COP_E_EXC_CODE = code;
  endtask

  initial begin
    int pulses;
    n_tests = 0;
    n_fail  = 0;
    idle();
    RST = 1'b0;
    bus.FLUSH = 1; bus.STALL = 1;
    tick();
    chk("rst_valid", 32'(bus.WB_VALID), 0);
    chk("rst_pc", bus.WB_PC, 0);
    chk("rst_cnt", 32'(bus.COP_RETIRE_CNT), 0);
    chk("rst_perr", 32'(bus.PROTO_ERR), 0);

    // Cop-only path
    idle();
    set_cop(32'h100, 5'd5, 32'hDEADBEEF, 0, 0);
    tick();
    chk("cop_valid", 32'(bus.WB_VALID), 1);
    chk("cop_pc", bus.WB_PC, 32'h100);
    chk("cop_rd", 32'(bus.WB_REG_W_RD), 5);
    chk("cop_data", bus.WB_REG_W_DATA, 32'hDEADBEEF);
    chk("cop_wen", 32'(bus.WB_REG_W_EN), 1);
    chk("cop_cnt", 32'(bus.COP_RETIRE_CNT), 1);
    idle();
    tick();
    chk("idle_valid", 32'(bus.WB_VALID), 0);

    // RD=0 and stall
    set_main(32'h140, 5'd0, 32'h55, 0, 0);
    tick();
    chk("rd0_valid", 32'(bus.WB_VALID), 1);
    chk("rd0_wen", 32'(bus.WB_REG_W_EN), 0);
    bus.STALL = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(bus.WB_VALID), 0);
    end
    bus.STALL = 0;
    pulses = 0;
    tick();
    pulses += int'(bus.WB_VALID);
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      pulses += int'(bus.WB_VALID);
    end
    chk("stall_pulses", 32'(pulses), 1);

    // Protocol conflict and TRAP
    set_main(32'h200, 5'd3, 32'h11, 0, 0);
    set_cop(32'h204, 5'd4, 32'h22, 0, 0);
    tick();
    chk("conf_valid", 32'(bus.WB_VALID), 1);
    chk("conf_pc", bus.WB_PC, 32'h200);
    chk("conf_exc", 32'(bus.WB_EXC_EN), 1);
    chk("conf_code", 32'(bus.WB_EXC_CODE), 2);
    chk("conf_wen", 32'(bus.WB_REG_W_EN), 0);
    chk("conf_perr", 32'(bus.PROTO_ERR), 1);
    chk("conf_cnt", 32'(bus.COP_RETIRE_CNT), 1);
    idle();
    set_main(32'h240, 5'd6, 32'h33, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("trap_valid", 32'(bus.WB_VALID), 0);
    end
    bus.FLUSH = 1;
    tick();
    chk("flush_valid", 32'(bus.WB_VALID), 0);
    chk("flush_exc", 32'(bus.WB_EXC_EN), 0);
    chk("flush_pc", bus.WB_PC, 32'h200);
    bus.FLUSH = 0;
    bus.MAIN_PC = 32'h300;
    tick();
    chk("post_flush_valid", 32'(bus.WB_VALID), 1);
    chk("post_flush_pc", bus.WB_PC, 32'h300);
    chk("perr_sticky", 32'(bus.PROTO_ERR), 1);

    // Reset mid-TRAP
    idle();
    set_main(32'h380, 5'd1, 32'h1, 1, 4'd5);
    tick();
    chk("mexc_exc", 32'(bus.WB_EXC_EN), 1);
    chk("mexc_code", 32'(bus.WB_EXC_CODE), 5);
    RST = 0;
    bus.FLUSH = 1;
    tick();
    chk("rst2_valid", 32'(bus.WB_VALID), 0);
    chk("rst2_exc", 32'(bus.WB_EXC_EN), 0);
    chk("rst2_pc", bus.WB_PC, 0);
    chk("rst2_perr", 32'(bus.PROTO_ERR), 0);
    idle();
    set_main(32'h400, 5'd7, 32'h1234, 0, 0);
    tick();
    chk("rst2_next_valid", 32'(bus.WB_VALID), 1);
    chk("rst2_next_pc", bus.WB_PC, 32'h400);
    chk("rst2_next_wen", 32'(bus.WB_REG_W_EN), 1);

    // Counter wrap (CNT_W=4)
    idle();
    for (int i = 0; i < 16; i++) begin
      set_cop(32'h500 + 32'(i * 4), 5'd1, 32'(i), 0, 0);
      tick();
      if (i == 14) chk("cnt_15", 32'(bus.COP_RETIRE_CNT), 15);
    end
    chk("cnt_wrap", 32'(bus.COP_RETIRE_CNT), 0);
    set_cop(32'h600, 5'd2, 32'h9, 1, 4'd7);
    tick();
    chk("cop_exc_cnt", 32'(bus.COP_RETIRE_CNT), 0);
    chk("cop_exc_en", 32'(bus.WB_EXC_EN), 1);
    chk("cop_exc_wen", 32'(bus.WB_REG_W_EN), 0);
    idle();
    bus.FLUSH = 1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RST            = ($urandom_range(0, 99) != 0);
      bus.FLUSH      = ($urandom_range(0, 9) == 0);
      bus.STALL      = ($urandom_range(0, 7) == 0);
      bus.MEM_WAIT   = ($urandom_range(0, 7) == 0);
      bus.MAIN_VALID = ($urandom_range(0, 1) == 0);
      bus.MAIN_PC    = $urandom();
      bus.MAIN_REG_W_EN   = ($urandom_range(0, 3) != 0);
      bus.MAIN_REG_W_RD   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.MAIN_REG_W_DATA = $urandom();
      bus.MAIN_EXC_EN     = ($urandom_range(0, 7) == 0);
      bus.MAIN_EXC_CODE   = 4'($urandom_range(0, 15));
      bus.COP_E_ALLOW     = ($urandom_range(0, 3) != 0);
      bus.COP_E_VALID     = ($urandom_range(0, 1) == 0);
      bus.COP_E_PC        = $urandom();
      bus.COP_E_REG_W_EN  = ($urandom_range(0, 3) != 0);
      bus.COP_E_REG_W_RD  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.COP_E_REG_W_DATA = $urandom();
      bus.COP_E_EXC_EN    = ($urandom_range(0, 7) == 0);
      bus.COP_E_EXC_CODE  = 4'($urandom_range(0, 15));
      tick();
    end
    idle();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
